// File: rtl/spi_slave_pkg.sv
// Shared constants and state encoding for the SPI slave register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package spi_slave_pkg;

   localparam int         CMD_WR_BIT    = 7;
   localparam int         ADDR_W        = 7;
   localparam logic [6:0] ADDR_FB_BASE  = 7'h40;
   localparam logic [6:0] ADDR_CMD      = 7'h7F;
   localparam int         CMD_START_BIT = 0;
   localparam int         CMD_STOP_BIT  = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into clk and flags sclk/cs_n edges.
// Latency: pin change visible as a one-clk edge flag SYNC_STAGES clk later.
// Backpressure: none; SPI pins cannot be stalled.
`timescale 1ns/1ps
module spi_edge_sync
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_q;
   logic                   cs_q;

   // Synchroniser chains plus one history flop for edge detection. The cs_n
   // chain resets to 0 so that a cs_n still low when reset releases is not
   // mistaken for a fresh frame start; only a genuine high-to-low opens one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sr <= '0;
         cs_sr   <= '0;
         mosi_sr <= '0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_q  <= sclk_sr[SYNC_STAGES-1];
         cs_q    <= cs_sr[SYNC_STAGES-1];
      end
   end

   assign sclk_rise = sclk_sr[SYNC_STAGES-1] & ~sclk_q;
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] & sclk_q;
   assign cs_fall   = ~cs_sr[SYNC_STAGES-1] & cs_q;
   assign cs_rise   = cs_sr[SYNC_STAGES-1] & ~cs_q;
   assign mosi_s    = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave: parameter registers, machine start/stop, coherent feedback reads.
// Latency: write/pulse commit SYNC_STAGES+1 clk after the last data sclk rise; miso MSB same.
// Backpressure: none; define SPI_BURST_EN to auto-increment the address across words.
`timescale 1ns/1ps
module spi_slave_regfile
   import spi_slave_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int NUM_REGS    = 4,
   parameter int NUM_FB      = 2,
   parameter int SYNC_STAGES = 2
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk,
   input  logic                       cs_n,
   input  logic                       mosi,
   output logic                       miso,
   input  logic [NUM_FB*DATA_W-1:0]   fb_data,
   output logic [NUM_REGS*DATA_W-1:0] reg_data,
   output logic                       machine_start,
   output logic                       machine_stop,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

`ifdef SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   localparam int CNT_W = $clog2(DATA_W);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

   spi_state_e                state_q, state_d;
   logic [DATA_W-2:0]         shift_q;
   logic [CNT_W-1:0]          bit_cnt_q;
   logic                      wr_q;
   logic                      first_q;
   logic [ADDR_W-1:0]         addr_q;
   logic [NUM_FB*DATA_W-1:0]  snap_q;
   logic [DATA_W-1:0]         miso_sr_q;
   logic [DATA_W-1:0]         regs_q [NUM_REGS];

   logic                      cmd_done, word_done;
   logic [7:0]                cmd_byte;
   logic [DATA_W-1:0]         data_word;
   logic                      word_active, wr_reg_hit, partial;
   logic                      do_reg_wr, do_cmd_wr, bad_wr, abort_err;
   logic [ADDR_W-1:0]         rd_addr;
   logic [DATA_W-1:0]         rd_word;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .mosi_s    (mosi_s)
   );

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state plus command/word completion; cs_n rise wins the state but a
   // word completing in the same clk still commits.
   always_comb begin
      state_d   = state_q;
      cmd_done  = 1'b0;
      word_done = 1'b0;
      case (state_q)
         ST_IDLE: if (cs_fall) state_d = ST_CMD;
         ST_CMD: begin
            cmd_done = sclk_rise && (bit_cnt_q == CNT_W'(7));
            if (cmd_done) state_d = ST_DATA;
            if (cs_rise)  state_d = ST_IDLE;
         end
         ST_DATA: begin
            word_done = sclk_rise && (bit_cnt_q == CNT_W'(DATA_W-1));
            if (cs_rise) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write decode and abort detection for the word/command in flight.
   always_comb begin
      cmd_byte    = {shift_q[6:0], mosi_s};
      data_word   = {shift_q, mosi_s};
      word_active = BURST || first_q;
      wr_reg_hit  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr_q == ADDR_W'(i)) wr_reg_hit = 1'b1;
      do_reg_wr = word_done && word_active && wr_q && wr_reg_hit;
      do_cmd_wr = word_done && word_active && wr_q && (addr_q == ADDR_CMD);
      bad_wr    = word_done && word_active && wr_q && !wr_reg_hit && (addr_q != ADDR_CMD);
      // Bits left dangling once this clk's sclk rise (if any) is absorbed.
      partial   = sclk_rise ? !(cmd_done || word_done) : (bit_cnt_q != '0);
      abort_err = cs_rise && partial &&
                  ((state_q == ST_CMD) || ((state_q == ST_DATA) && word_active));
   end

   // Read mux: the address being loaded is the command address on command
   // completion, otherwise the post-incremented burst address.
   always_comb begin
      rd_addr = cmd_done ? cmd_byte[ADDR_W-1:0] : addr_q + ADDR_W'(1);
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rd_addr == ADDR_W'(i)) rd_word = regs_q[i];
      for (int i = 0; i < NUM_FB; i++)
         if (rd_addr == ADDR_FB_BASE + ADDR_W'(i)) rd_word = snap_q[i*DATA_W +: DATA_W];
   end

   // Shift-in, bit counting, address tracking, feedback snapshot and miso shifter.
   // The miso shifter holds on the fall right after a load so the MSB is
   // presented for the first data rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
         wr_q      <= 1'b0;
         first_q   <= 1'b0;
         addr_q    <= '0;
         snap_q    <= '0;
         miso_sr_q <= '0;
      end else if (state_q == ST_IDLE) begin
         bit_cnt_q <= '0;
         first_q   <= 1'b0;
         miso_sr_q <= '0;
         if (cs_fall) snap_q <= fb_data;
      end else begin
         if (sclk_rise) begin
            shift_q   <= data_word[DATA_W-2:0];
            bit_cnt_q <= (cmd_done || word_done) ? '0 : bit_cnt_q + CNT_W'(1);
         end
         if (cmd_done) begin
            wr_q      <= cmd_byte[CMD_WR_BIT];
            addr_q    <= cmd_byte[ADDR_W-1:0];
            first_q   <= 1'b1;
            miso_sr_q <= cmd_byte[CMD_WR_BIT] ? '0 : rd_word;
         end else if (word_done) begin
            first_q <= 1'b0;
            if (BURST) begin
               addr_q    <= addr_q + ADDR_W'(1);
               miso_sr_q <= wr_q ? '0 : rd_word;
            end else begin
               miso_sr_q <= '0;
            end
         end else if (sclk_fall && (state_q == ST_DATA) && (bit_cnt_q != '0)) begin
            miso_sr_q <= {miso_sr_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   // Register file commit and one-clk status pulses; stop overrides start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_strobe     <= 1'b0;
         wr_addr       <= '0;
         machine_start <= 1'b0;
         machine_stop  <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         if (do_reg_wr) begin
            for (int i = 0; i < NUM_REGS; i++)
               if (addr_q == ADDR_W'(i)) regs_q[i] <= data_word;
            wr_addr <= addr_q;
         end
         wr_strobe     <= do_reg_wr;
         machine_stop  <= do_cmd_wr && data_word[CMD_STOP_BIT];
         machine_start <= do_cmd_wr && data_word[CMD_START_BIT] && !data_word[CMD_STOP_BIT];
         frame_err     <= bad_wr || abort_err;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_data[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign miso = (state_q == ST_DATA) && miso_sr_q[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed scenarios plus random frames.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_slave_regfile;

   localparam int DATA_W      = 16;
   localparam int NUM_REGS    = 4;
   localparam int NUM_FB      = 2;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 50;   // sclk half period in ns (clk period 10 ns)
`ifdef SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic                       sclk = 1'b0;
   logic                       cs_n = 1'b1;
   logic                       mosi = 1'b0;
   logic                       miso;
   logic [NUM_FB*DATA_W-1:0]   fb_data = '0;
   logic [NUM_REGS*DATA_W-1:0] reg_data;
   logic                       machine_start, machine_stop, wr_strobe, frame_err;
   logic [6:0]                 wr_addr;

   spi_slave_regfile #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_FB(NUM_FB), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .fb_data(fb_data), .reg_data(reg_data), .machine_start(machine_start),
      .machine_stop(machine_stop), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Pulse monitors: count high cycles so a stretched pulse shows up as extra.
   int  n_strobe = 0, n_start = 0, n_stop = 0, n_err = 0;
   time t_strobe = 0;
   always @(negedge clk) begin
      if (wr_strobe === 1'b1)     begin n_strobe++; t_strobe = $time; end
      if (machine_start === 1'b1) n_start++;
      if (machine_stop === 1'b1)  n_stop++;
      if (frame_err === 1'b1)     n_err++;
   end

   // Reference model state.
   logic [NUM_REGS*DATA_W-1:0] mdl_regs = '0;
   logic [NUM_FB*DATA_W-1:0]   mdl_snap = '0;
   logic [6:0]                 mdl_wr_addr = '0;
   int                         e_strobe, e_start, e_stop, e_err;
   logic [DATA_W-1:0]          tx_q[$];
   logic [DATA_W-1:0]          rx_q[$];
   logic [DATA_W-1:0]          exp_q[$];

   int  total = 0, bad = 0;
   time t_rise = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mdl_read(input logic [6:0] a);
      int ai;
      ai = int'(a);
      if (ai < NUM_REGS) return mdl_regs[ai*DATA_W +: DATA_W];
      if (ai >= 'h40 && ai < 'h40 + NUM_FB) return mdl_snap[(ai-'h40)*DATA_W +: DATA_W];
      return '0;
   endfunction

   // Applies a whole frame's effect to the model and lists the expected read words.
   task automatic model_frame(input bit wr, input logic [6:0] a0, input int nw);
      logic [6:0] a;
      a = a0;
      exp_q = {};
      for (int k = 0; k < nw; k++) begin
         if (!BURST && k > 0) begin
            exp_q.push_back('0);
         end else begin
            exp_q.push_back(wr ? '0 : mdl_read(a));
            if (wr) begin
               if (int'(a) < NUM_REGS) begin
                  mdl_regs[int'(a)*DATA_W +: DATA_W] = tx_q[k];
                  mdl_wr_addr = a;
                  e_strobe++;
               end else if (a == 7'h7F) begin
                  if (tx_q[k][1])      e_stop++;
                  else if (tx_q[k][0]) e_start++;
               end else begin
                  e_err++;
               end
            end
            a = a + 7'd1;
         end
      end
   endtask

   task automatic spi_shift(input logic [15:0] tx, input int n, output logic [15:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         mosi = tx[i];
         #HALF;
         rx[i] = miso;
         sclk = 1'b1;
         t_rise = $time;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic spi_begin();
      cs_n = 1'b0;
      #(2*HALF);
   endtask

   task automatic spi_end();
      #HALF;
      cs_n = 1'b1;
      #(4*HALF);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NUM_REGS; i++)
         check({tag, "_reg"}, reg_data[i*DATA_W +: DATA_W], mdl_regs[i*DATA_W +: DATA_W]);
      check({tag, "_wr_addr"}, wr_addr, mdl_wr_addr);
   endtask

   // Full frame from tx_q against the model, then all observable effects.
   task automatic do_frame(input string tag, input bit wr, input logic [6:0] a, input int nw);
      int s0, st0, sp0, er0;
      logic [15:0] rx;
      s0 = n_strobe; st0 = n_start; sp0 = n_stop; er0 = n_err;
      e_strobe = 0; e_start = 0; e_stop = 0; e_err = 0;
      mdl_snap = fb_data;
      model_frame(wr, a, nw);
      spi_begin();
      spi_shift({8'h00, wr, a}, 8, rx);
      rx_q = {};
      for (int k = 0; k < nw; k++) begin
         spi_shift(tx_q[k], 16, rx);
         rx_q.push_back(rx);
      end
      spi_end();
      if (!wr)
         for (int k = 0; k < nw; k++) check({tag, "_rx"}, rx_q[k], exp_q[k]);
      check({tag, "_strobes"}, n_strobe - s0, e_strobe);
      check({tag, "_starts"}, n_start - st0, e_start);
      check({tag, "_stops"}, n_stop - sp0, e_stop);
      check({tag, "_errs"}, n_err - er0, e_err);
      check_regs(tag);
   endtask

   bit          r_wr;
   logic [6:0]  r_addr;
   int          r_nw, s0, er0;
   logic [15:0] rx;

   initial begin
      // Reset state
      #33;
      check("rst_reg_data", reg_data, '0);
      check("rst_miso", miso, 1'b0);
      check("rst_wr_addr", wr_addr, 7'd0);
      check("rst_pulses", {machine_start, machine_stop, wr_strobe, frame_err}, 4'b0000);
      rst_n = 1'b1;
      #100;

      // Single write to reg 2, with commit latency bound
      tx_q = {16'h1234};
      do_frame("wr02", 1'b1, 7'h02, 1);
      check("wr02_latency", (t_strobe - t_rise) <= (SYNC_STAGES + 2) * 10, 1'b1);

      // Feedback read stays coherent even though ch1 changes during the frame
      fb_data = {16'hABCD, 16'h5555};
      spi_begin();
      spi_shift(16'h0004, 4, rx);
      fb_data[31:16] = 16'h0000;
      spi_shift(16'h0001, 4, rx);
      spi_shift(16'h0000, 16, rx);
      spi_end();
      check("fb_coherent", rx, 16'hABCD);

      // Command register: both bits -> stop only; then start alone
      tx_q = {16'h0003};
      do_frame("cmd_both", 1'b1, 7'h7F, 1);
      tx_q = {16'h0001};
      do_frame("cmd_start", 1'b1, 7'h7F, 1);

      // Burst write and burst read-back from reg 0
      tx_q = {16'h1111, 16'h2222, 16'h3333};
      do_frame("burst_wr", 1'b1, 7'h00, 3);
      tx_q = {16'h0000, 16'h0000, 16'h0000};
      do_frame("burst_rd", 1'b0, 7'h00, 3);

      // Unmapped write and write to a feedback address
      tx_q = {16'hBEEF};
      do_frame("wr_unmapped", 1'b1, 7'h20, 1);
      tx_q = {16'hBEEF};
      do_frame("wr_fb", 1'b1, 7'h40, 1);

      // cs_n raised after 9 of 16 data bits to reg 1
      s0 = n_strobe; er0 = n_err;
      spi_begin();
      spi_shift(16'h0081, 8, rx);
      spi_shift(16'h01A5, 9, rx);
      spi_end();
      check("abort_strobes", n_strobe - s0, 0);
      check("abort_errs", n_err - er0, 1);
      check_regs("abort");
      tx_q = {16'h5A5A};
      do_frame("after_abort", 1'b1, 7'h01, 1);

      // cs_n rise detected together with the last data sclk rise: word commits
      s0 = n_strobe; er0 = n_err;
      spi_begin();
      spi_shift(16'h0083, 8, rx);
      spi_shift(16'hC3C3 >> 1, 15, rx);
      mosi = 1'b1;
      #HALF;
      sclk = 1'b1;
      cs_n = 1'b1;
      #HALF;
      sclk = 1'b0;
      #(4*HALF);
      mdl_regs[3*DATA_W +: DATA_W] = 16'hC3C3;
      mdl_wr_addr = 7'd3;
      check("csr_same_strobes", n_strobe - s0, 1);
      check("csr_same_errs", n_err - er0, 0);
      check_regs("csr_same");

      // Reset in the middle of a read
      fb_data = {16'h7777, 16'h8888};
      spi_begin();
      spi_shift(16'h0040, 8, rx);
      spi_shift(16'h0000, 5, rx);
      rst_n = 1'b0;
      #30;
      check("midrst_reg_data", reg_data, '0);
      check("midrst_miso", miso, 1'b0);
      check("midrst_wr_addr", wr_addr, 7'd0);
      check("midrst_pulses", {machine_start, machine_stop, wr_strobe, frame_err}, 4'b0000);
      mdl_regs = '0;
      mdl_wr_addr = '0;
      rst_n = 1'b1;
      #HALF;
      er0 = n_err;
      spi_shift(16'h000F, 4, rx);
      spi_end();
      check("midrst_no_err", n_err - er0, 0);
      tx_q = {16'h00FF};
      do_frame("post_rst_wr", 1'b1, 7'h00, 1);

      // Random frames against the model
      for (int f = 0; f < 20; f++) begin
         r_wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       r_addr = 7'($urandom_range(0, NUM_REGS - 1));
            1:       r_addr = 7'h40 + 7'($urandom_range(0, NUM_FB));
            2:       r_addr = 7'h7F;
            default: r_addr = 7'($urandom_range(0, 127));
         endcase
         r_nw = $urandom_range(1, 3);
         tx_q = {};
         for (int k = 0; k < r_nw; k++) tx_q.push_back(16'($urandom));
         fb_data = 32'($urandom);
         do_frame("rand", r_wr, r_addr, r_nw);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
